// File: rtl/ssd_scan_driver.sv
// ssd_scan_driver
//   Drives a common-anode, multiplexed 7-segment display from packed BCD.
//   Features: anode scanning, segment decode, blank code, leading-zero
//   suppression, a blanking gap at the start of each slot to stop ghosting,
//   and frame-synchronous updates so that one frame never shows two values.
//
// Ports
//   CLK          system clock
//   RSTn         asynchronous active-low reset
//   display      display enable; 0 turns the display off and holds the scan
//   bcd_in       packed BCD, nibble k = digit k (digit 0 is rightmost)
//   load         one-cycle strobe that captures bcd_in
//   dp_mask      decimal point per digit, 1 = lit
//   an           anode enables, active-low
//   seg          cathodes {g,f,e,d,c,b,a}, active-low
//   dp           decimal point cathode, active-low
//   frame_start  one-cycle pulse when the digit 0 slot begins
module ssd_scan_driver #(
  parameter int DIGITS       = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int LZ_SUPPRESS  = 1
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  input  logic                  display,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic                  load,
  input  logic [DIGITS-1:0]     dp_mask,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame_start
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] BLANK_END = PW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

  logic [PW-1:0]       presc_q, presc_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0] pending_q, pending_d;
  logic [4*DIGITS-1:0] shown_q, shown_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic                fs_q, fs_d;

  logic [3:0]          nib [DIGITS];
  logic [DIGITS-1:0]   lz_blank;

  function automatic logic [6:0] dec7(input logic [3:0] n);
    case (n)
      4'h0:    dec7 = 7'h40;
      4'h1:    dec7 = 7'h79;
      4'h2:    dec7 = 7'h24;
      4'h3:    dec7 = 7'h30;
      4'h4:    dec7 = 7'h19;
      4'h5:    dec7 = 7'h12;
      4'h6:    dec7 = 7'h02;
      4'h7:    dec7 = 7'h78;
      4'h8:    dec7 = 7'h00;
      4'h9:    dec7 = 7'h10;
      4'hA:    dec7 = 7'h3F;
      default: dec7 = 7'h7F;
    endcase
  endfunction

  // Scan state and the pending/shown double buffer. shown only moves at the
  // frame boundary (or continuously while the display is off), and a load in
  // the boundary cycle bypasses pending straight into shown.
  always_comb begin
    pending_d = load ? bcd_in : pending_q;
    presc_d   = presc_q;
    idx_d     = idx_q;
    shown_d   = shown_q;
    if (!display) begin
      presc_d = '0;
      idx_d   = '0;
      shown_d = pending_d;
    end else if (presc_q == PRE_LAST) begin
      presc_d = '0;
      if (idx_q == IDX_LAST) begin
        idx_d   = '0;
        shown_d = pending_d;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end else begin
      presc_d = presc_q + 1'b1;
    end
  end

  // Leading-zero scan from the most significant digit down. Blank-code
  // nibbles keep the leading run going; any digit 1-9 or the dash ends it.
  always_comb begin : lz_scan
    logic lead;
    lead     = 1'b1;
    lz_blank = '0;
    nib      = '{default: '0};
    for (int unsigned k = DIGITS; k > 0; k--) begin
      nib[k-1]      = shown_q[4*(k-1) +: 4];
      lz_blank[k-1] = (LZ_SUPPRESS != 0) && lead && (k != 1) && (nib[k-1] == 4'h0);
      if ((nib[k-1] >= 4'h1) && (nib[k-1] <= 4'hA)) lead = 1'b0;
    end
  end

  always_comb begin
    an_d  = '1;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    fs_d  = 1'b0;
    if (display) begin
      fs_d = (presc_q == '0) && (idx_q == '0);
      if (presc_q >= BLANK_END) begin
        an_d[idx_q] = 1'b0;
        seg_d       = lz_blank[idx_q] ? 7'h7F : dec7(nib[idx_q]);
        dp_d        = ~dp_mask[idx_q];
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      presc_q   <= '0;
      idx_q     <= '0;
      pending_q <= '1;
      shown_q   <= '1;
      an_q      <= '1;
      seg_q     <= 7'h7F;
      dp_q      <= 1'b1;
      fs_q      <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      shown_q   <= shown_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      fs_q      <= fs_d;
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign dp          = dp_q;
  assign frame_start = fs_q;

endmodule

// File: doc/ssd_scan_driver.md
Name: ssd_scan_driver

Overview:
Consumer end of the station temperature display path. Accepts packed BCD digits from the BCD conversion stage and time-multiplexes them onto the board's common-anode 4-digit 7-segment display. It provides anode scanning, segment decode, the blank code, leading-zero suppression, anti-ghosting blanking, and tear-free frame-synchronous updates.

Parameters:
DIGITS, 4, number of multiplexed digits (digit 0 = least significant, rightmost)
REFRESH_DIV, 100000, CLK cycles per digit slot (1 ms at 100 MHz); must be >= 2
BLANK_CYCLES, 1000, cycles at the start of each slot with all anodes off; must be < REFRESH_DIV
LZ_SUPPRESS, 1, 1 = blank leading zero digits

Ports:
CLK  in  1  100 MHz system clock
RSTn  in  1  asynchronous active-low reset
display  in  1  display enable (CorrectStation-qualified)
bcd_in  in  4*DIGITS  packed BCD, nibble k = digit k
load  in  1  one-cycle strobe; capture bcd_in
dp_mask  in  DIGITS  decimal point per digit, 1 = lit
an  out  DIGITS  anode enables, active-low
seg  out  7  cathodes {g,f,e,d,c,b,a}, active-low
dp  out  1  decimal point cathode, active-low
frame_start  out  1  one-cycle pulse when digit 0 slot begins

Behaviour:
- One clock domain: CLK. Reset is asynchronous and active-low on RSTn.
- Reset values:
  - an = all 1, seg = 7'h7F, dp = 1, frame_start = 0.
  - prescaler = 0, digit index = 0.
  - pending and shown registers = all nibbles 4'hF (blank).
- Prescaler counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, the digit index advances.
  - It goes from DIGITS-1 back to 0 (frame boundary).
- Load handshake:
  - A cycle with load=1 captures bcd_in into pending.
  - load has no acknowledge. Back-to-back loads are legal; the last one wins.
- Frame boundary: the cycle in which the index goes from DIGITS-1 to 0.
  - shown <= (load ? bcd_in : pending).
  - A load in the same cycle bypasses pending into shown. pending also captures it.
  - shown changes only at this boundary, so a frame never mixes two values.
- Nibble decode (hex value, seg):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - A = dash, 3F.
  - B through F = blank, 7F.
- Leading-zero suppression (LZ_SUPPRESS=1):
  - Scanning from digit DIGITS-1 downward, zero nibbles are blanked until the first nonzero nibble.
  - Digit 0 is never suppressed.
  - Blank-code nibbles (B–F) count as leading for this purpose.
- Blanking interval: while prescaler < BLANK_CYCLES, an = all 1.
  - seg is don't-care in this interval but must be driven 7'h7F.
- Active portion of a slot (prescaler >= BLANK_CYCLES):
  - an[index] = 0; all other anode bits = 1.
  - seg = decode of the current digit.
  - dp = ~dp_mask[index].
- All outputs are registered: one cycle latency from the prescaler/index state.
- frame_start is asserted in the registered cycle following the frame boundary.
- display = 0:
  - Prescaler and index are held at 0.
  - an = all 1, seg = 7'h7F, dp = 1, frame_start = 0.
  - load is still accepted into pending.
  - shown is updated from pending immediately each cycle, so re-enabling shows the latest value.
- display rising: scanning starts at digit 0 with a blanking interval. The first frame_start is issued one cycle later.
- RSTn asserted mid-slot: all outputs go to reset values immediately, asynchronously, with no glitch to a lit state.

Test Plan:
(Bench parameters: REFRESH_DIV=8, BLANK_CYCLES=2, DIGITS=4.)
1. Release reset with display=1 and no load.
   - Required: all digits blank (seg=7F every slot).
   - Required: an cycles 1110 -> 1101 -> 1011 -> 0111, each low for 6 cycles after 2 off cycles.
   - Required: frame_start pulses every 32 cycles.
2. load with bcd_in=16'h0072 and LZ_SUPPRESS=1.
   - Required: digits 3 and 2 are blank; digit 1 seg=78, digit 0 seg=24.
   - Required: the change appears only after the next frame_start.
3. bcd_in=16'h0000.
   - Required: digits 3..1 are blank; digit 0 shows 40.
   - Required: with LZ_SUPPRESS=0, all four digits show 40.
4. load=1 on the exact frame-boundary cycle with 16'h1234.
   - Required: the frame that begins shows 1,2,3,4 (digit 3 seg=79, digit 0 seg=19), not the old value.
   - Repeat with load 3 cycles mid-frame: required that the old value completes the frame.
5. Drop display mid-slot.
   - Required: an=all 1 next cycle.
   - Then load 16'hFFA5 and raise display. Required: digit 1 seg=3F, digit 0 seg=12, digits 3 and 2 blank.
   - Required: dp_mask=4'b0010 gives dp=0 only during the active portion of digit 1.
6. Pulse RSTn low at prescaler=5 of digit 2.
   - Required: an=1111 and seg=7F asynchronously; the shown value returns to blank.
